seq_det_param_moore: RTL and testbench
======================================

# seq_det_param_moore

Parametrised multi-pattern Moore sequence detector for a serial bit stream: the generalised successor of our fixed 101/110 non-overlapping detectors. It compares the last PAT_LEN received bits against NUM_PAT run-time programmable patterns. Overlapping or non-overlapping detection is selected at run time. It sits directly on a 1-bit serial input, and its registered match flags drive downstream control logic or event counters.

## Interface
- PAT_LEN, 3: pattern length in bits; legal range 2..16.
- NUM_PAT, 2: number of independent patterns; legal range 1..8.
- CNT_W, 8: match-counter width; used only with SEQ_DET_COUNT_EN.
- clk  in  1  rising-edge clock; single clock domain.
- rstn  in  1  synchronous, active-low reset; sampled on posedge clk.
- in  in  1  serial data bit; one bit sampled per clock while rstn=1.
- pat  in  NUM_PAT*PAT_LEN  patterns; pattern k = pat[k*PAT_LEN +: PAT_LEN], MSB = oldest (first received) bit.
- ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- match  out  NUM_PAT  per-pattern registered hit flags.
- out  out  1  OR of match.
- match_cnt  out  CNT_W  saturating count of cycles with out=1 (SEQ_DET_COUNT_EN only).

## Operation
- State is a PAT_LEN-bit history register hist plus a fill counter fill, where fill counts valid bits 0..PAT_LEN. hist[0] is the newest bit.
- On every posedge with rstn=1:
  - next_hist = {hist[PAT_LEN-2:0], in}.
  - next_fill = min(fill+1, PAT_LEN).
- Hit evaluation: hit[k] = (next_fill==PAT_LEN) && (next_hist == pattern k). match <= hit.
- Non-overlapping (ovl=0): if any hit[k], fill <= 0. The next detection then requires PAT_LEN fresh bits. hist still loads next_hist, which is don't-care while fill<PAT_LEN.
- Overlapping (ovl=1): fill is not cleared on a hit. Every new bit can produce a match once the history is full.
- Multiple simultaneous hits (identical patterns programmed twice) set all corresponding match bits. The non-overlap clear happens once.
- pat and ovl are sampled combinationally at each edge; a change takes effect on the next sampled bit. The history is never re-scanned.
- Outputs depend only on registered state (Moore); no combinational path from in to match/out.
- Reset: hist=0, fill=0, match=0, out=0, match_cnt=0. A reset mid-stream discards all partial history.

## Timing
- Latency: the edge that samples the final pattern bit sets match/out, visible immediately after that edge for exactly one cycle.
- The following edge clears match unless a new hit occurs. A new hit is possible only in overlap mode, or in non-overlap mode after PAT_LEN further bits.
- Minimum spacing between out pulses is 1 cycle in overlap mode and PAT_LEN cycles in non-overlap mode.
- After reset release, the first possible match occurs on the PAT_LEN-th sampling edge with rstn=1.
- rstn=0 on an edge overrides everything; outputs read 0 after that edge.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - match_cnt increments by 1 on each edge where the registered out becomes/stays 1 for that cycle, i.e. it counts hit events.
  - It saturates at 2^CNT_W-1 with no wrap, and resets to 0 on rstn=0.
- Undefined: the match_cnt port and counter logic are absent; the port list ends at out.

## Test plan
- Defaults, pat={3'b110,3'b101}, ovl=0; after reset feed 1,0,1,0,1:
  - match=2'b01 for one cycle after the 3rd bit.
  - No match after the 5th bit.
- Same stream with ovl=1: match=2'b01 after bit 3 and again after bit 5. out pulses twice.
- ovl=1, feed 1,1,0,1:
  - match=2'b10 after bit 3, then 2'b01 after bit 4.
  - With ovl=0, only 2'b10 after bit 3.
- Reset mid-stream: feed 1,0; hold rstn=0 for one edge; release and feed 1. Required: no match, and all outputs 0 during and after reset.
- PAT_LEN=5, NUM_PAT=1, pat=5'b11111, ovl=1, feed seven 1s: out=1 after bits 5, 6 and 7. With ovl=0: out=1 after bit 5 only.
- SEQ_DET_COUNT_EN, CNT_W=2, ovl=1, pattern 101, feed 1,0,1,0,1,0,1,0,1,0,1 (5 hits): match_cnt steps 1,2,3 and then holds 3.

Source files
------------

// File: rtl/seq_det_param_moore.sv
// Parametrised multi-pattern Moore sequence detector on a serial bit stream.
// Optional saturating hit counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det_param_moore #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       in_i,
  input  logic [NUM_PAT*PAT_LEN-1:0] pat_i,
  input  logic                       ovl_i,
  output logic [NUM_PAT-1:0]         match_o,
  output logic                       out_o
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]           match_cnt_o
`endif
);

  localparam int unsigned FillW = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d, fill_inc;
  logic [NUM_PAT-1:0] match_q, hit;
  logic               out_q;

  always_comb begin
    hist_d   = {hist_q[PAT_LEN-2:0], in_i};
    fill_inc = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
    hit      = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      hit[k] = (fill_inc == FillFull) && (hist_d == pat_i[k*PAT_LEN +: PAT_LEN]);
    end
    // Non-overlap mode restarts the fill so the next hit needs PAT_LEN fresh bits.
    fill_d = (!ovl_i && (|hit)) ? '0 : fill_inc;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      out_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit;
      out_q   <= |hit;
    end
  end

  assign match_o = match_q;
  assign out_o   = out_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if ((|hit) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_param_moore.sv
// Self-checking bench for seq_det_param_moore: queue-based stream model plus directed literals.
module tb_seq_det_param_moore;

  logic clk = 1'b0;
  logic rstn, in_b, ovl;
  logic [5:0] pat0 = {3'b110, 3'b101};
  logic [4:0] pat1 = 5'b11111;
  logic [2:0] pat2 = 3'b101;
  logic [1:0] match0;
  logic       out0;
  logic [0:0] match1;
  logic       out1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [0:0] match2;
  logic       out2;
  logic [1:0] cnt2;
`endif

  seq_det_param_moore #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .in_i(in_b), .pat_i(pat0), .ovl_i(ovl),
    .match_o(match0), .out_o(out0)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt_o(cnt0)
`endif
  );

  seq_det_param_moore #(.PAT_LEN(5), .NUM_PAT(1), .CNT_W(8)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .in_i(in_b), .pat_i(pat1), .ovl_i(ovl),
    .match_o(match1), .out_o(out1)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt_o(cnt1)
`endif
  );

`ifdef SEQ_DET_COUNT_EN
  seq_det_param_moore #(.PAT_LEN(3), .NUM_PAT(1), .CNT_W(2)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .in_i(in_b), .pat_i(pat2), .ovl_i(ovl),
    .match_o(match2), .out_o(out2), .match_cnt_o(cnt2)
  );
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the bits received since the last reset or non-overlap clear, newest at the back.
  int stream[3][$];

  function automatic logic [7:0] model_step(input int id, input bit b, input bit o,
                                            input int plen, input int npat,
                                            input logic [63:0] pv);
    logic [7:0] h = '0;
    longint v = 0;
    stream[id].push_back(int'(b));
    if (stream[id].size() > plen) void'(stream[id].pop_front());
    if (stream[id].size() == plen) begin
      foreach (stream[id][i]) v = v * 2 + stream[id][i];
      for (int k = 0; k < npat; k++) begin
        if (((pv >> (k * plen)) & ((64'd1 << plen) - 1)) == 64'(v)) h[k] = 1'b1;
      end
    end
    if (h != 0 && !o) stream[id].delete();
    return h;
  endfunction

  logic [1:0] exp0 = '0;
  logic       exp1 = 1'b0;
  logic       exp2 = 1'b0;
  logic       valid = 1'b0;
  logic       rst_seen = 1'b0;

  always @(posedge clk) begin
    rst_seen <= !rstn;
    if (!rstn) begin
      stream[0].delete();
      stream[1].delete();
      stream[2].delete();
      exp0  <= '0;
      exp1  <= 1'b0;
      exp2  <= 1'b0;
      valid <= 1'b1;
    end else begin
      exp0 <= 2'(model_step(0, in_b, ovl, 3, 2, 64'(pat0)));
      exp1 <= 1'(model_step(1, in_b, ovl, 5, 1, 64'(pat1)));
      exp2 <= 1'(model_step(2, in_b, ovl, 3, 1, 64'(pat2)));
    end
  end

  int mcnt = 0;

  always @(negedge clk) begin
    if (valid) begin
      chk("cyc_match0", int'(match0), int'(exp0));
      chk("cyc_out0", int'(out0), int'(|exp0));
      chk("cyc_match1", int'(match1), int'(exp1));
      chk("cyc_out1", int'(out1), int'(exp1));
`ifdef SEQ_DET_COUNT_EN
      if (rst_seen) mcnt = 0;
      else if (exp2 && mcnt < 3) mcnt++;
      chk("cyc_cnt2", int'(cnt2), mcnt);
      chk("cyc_out2", int'(out2), int'(exp2));
`endif
    end
  end

  task automatic tick(input bit b);
    in_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(1'b0);
    rstn = 1'b1;
  endtask

  int pulses;
  logic [10:0] alt = 11'b10101010101;

  initial begin
    rstn = 1'b0;
    in_b = 1'b0;
    ovl  = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("reset_match", int'(match0), 0);
    chk("reset_out", int'(out0), 0);
    rstn = 1'b1;

    // Non-overlap: 1,0,1,0,1
    tick(1); tick(0); tick(1);
    chk("novl_101_bit3", int'(match0), 2'b01);
    chk("novl_101_out", int'(out0), 1);
    tick(0);
    chk("novl_bit4", int'(match0), 0);
    tick(1);
    chk("novl_bit5", int'(match0), 0);

    // Overlap: same stream
    do_reset();
    ovl = 1'b1;
    tick(1); tick(0); tick(1);
    chk("ovl_bit3", int'(match0), 2'b01);
    tick(0);
    chk("ovl_bit4", int'(match0), 0);
    tick(1);
    chk("ovl_bit5", int'(match0), 2'b01);

    // 1,1,0,1 in both modes
    do_reset();
    tick(1); tick(1); tick(0);
    chk("ovl_110", int'(match0), 2'b10);
    tick(1);
    chk("ovl_101_after_110", int'(match0), 2'b01);
    do_reset();
    ovl = 1'b0;
    tick(1); tick(1); tick(0);
    chk("novl_110", int'(match0), 2'b10);
    tick(1);
    chk("novl_after_110", int'(match0), 0);

    // Reset mid-stream
    do_reset();
    tick(1); tick(0);
    rstn = 1'b0;
    tick(1);
    chk("midrst_match", int'(match0), 0);
    chk("midrst_out", int'(out0), 0);
    rstn = 1'b1;
    tick(1);
    chk("midrst_after", int'(out0), 0);

    // PAT_LEN=5 all-ones, overlap then non-overlap
    do_reset();
    ovl = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk($sformatf("ones_ovl_bit%0d", i), int'(out1), (i >= 5) ? 1 : 0);
    end
    do_reset();
    ovl = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk($sformatf("ones_novl_bit%0d", i), int'(out1), (i == 5) ? 1 : 0);
    end

    // Alternating stream, overlap: five 101 hits
    do_reset();
    ovl = 1'b1;
    pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      tick(alt[i]);
      if (out0) pulses++;
`ifdef SEQ_DET_COUNT_EN
      if (i == 8) chk("cnt_bit3", int'(cnt2), 1);
      if (i == 6) chk("cnt_bit5", int'(cnt2), 2);
      if (i == 4) chk("cnt_bit7", int'(cnt2), 3);
`endif
    end
    chk("alt_pulses", pulses, 5);
`ifdef SEQ_DET_COUNT_EN
    chk("cnt_sat", int'(cnt2), 3);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
